// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD sequencer.
package sad_pkg;

  localparam int DATA_W = 32;

  // ALU control codes, identical to the ones the pipeline's EX stage decodes.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    SUB,
    ABS,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/sad_addr_gen.sv
// Window walker: row/col counters plus a running row offset, producing the
// byte addresses of the current element in both frames.
module sad_addr_gen #(
  parameter int WIN_W   = 4,
  parameter int WIN_H   = 4,
  parameter int FRAME_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        step,
  input  logic [31:0] base_a,
  input  logic [31:0] base_b,
  output logic        last,
  output logic [31:0] addr_a,
  output logic [31:0] addr_b
);

  localparam int COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam logic [31:0]      ROW_BYTES = 32'(4 * FRAME_W);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(WIN_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [31:0]      row_off;
  logic [31:0]      col_off;

  // Advance column on each step; on column wrap move the row offset down one frame row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      row_off <= '0;
    end else if (clear) begin
      col     <= '0;
      row     <= '0;
      row_off <= '0;
    end else if (step) begin
      if (col == COL_LAST) begin
        col     <= '0;
        row     <= row + ROW_W'(1);
        row_off <= row_off + ROW_BYTES;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign col_off = {{(32 - COL_W - 2){1'b0}}, col, 2'b00};
  assign addr_a  = base_a + row_off + col_off;
  assign addr_b  = base_b + row_off + col_off;
  assign last    = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/sad_alu_sequencer.sv
// Borrows the shared EX-stage ALU to accumulate the sum of absolute
// differences between two word windows read from data memory.
module sad_alu_sequencer
  import sad_pkg::*;
#(
  parameter int WIN_W   = 4,
  parameter int WIN_H   = 4,
  parameter int FRAME_W = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] BaseA,
  input  logic [31:0] BaseB,
  output logic        MemRdEn,
  output logic [31:0] MemAddrA,
  output logic [31:0] MemAddrB,
  input  logic [31:0] MemDataA,
  input  logic [31:0] MemDataB,
  output logic        AluReq,
  input  logic        AluGnt,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluCtl,
  input  logic [31:0] AluResult,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] SadOut
);

  state_t state, nstate;

  logic [DATA_W-1:0]        base_a, base_b;
  logic                     vld_p1;
  logic [DATA_W-1:0]        data_a_p1, data_b_p1;
  logic [DATA_W-1:0]        opa_p1, opb_p1;
  logic signed [DATA_W-1:0] diff_p2;
  logic signed [DATA_W-1:0] acc_p3;
  logic [DATA_W-1:0]        sad_q;
  logic                     clear, step, last;
  logic                     cap_diff, cap_acc;

  // Sign of a freshly computed difference decides whether the ABS pass is needed.
  function automatic logic is_neg(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction

  sad_addr_gen #(
    .WIN_W  (WIN_W),
    .WIN_H  (WIN_H),
    .FRAME_W(FRAME_W)
  ) u_addr (
    .clk   (Clk),
    .rst_n (Rst),
    .clear (clear),
    .step  (step),
    .base_a(base_a),
    .base_b(base_b),
    .last  (last),
    .addr_a(MemAddrA),
    .addr_b(MemAddrB)
  );

  // Read data is live on the memory ports only in the cycle after RD; afterwards
  // the captured copy is used, so an ALU stall in SUB does not lose the operands.
  assign opa_p1 = vld_p1 ? MemDataA : data_a_p1;
  assign opb_p1 = vld_p1 ? MemDataB : data_b_p1;

  // Control state: FSM register, read-valid flag and captured window bases.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
      base_a <= '0;
      base_b <= '0;
    end else begin
      state  <= nstate;
      vld_p1 <= MemRdEn;
      if (clear) begin
        base_a <= BaseA;
        base_b <= BaseB;
      end
    end
  end

  // Datapath registers: fetched operands, difference, accumulator, final result.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      diff_p2   <= '0;
      acc_p3    <= '0;
      sad_q     <= '0;
    end else begin
      // ---- read capture ----
      if (vld_p1) begin
        data_a_p1 <= MemDataA;
        data_b_p1 <= MemDataB;
      end
      // ---- difference / absolute value ----
      if (clear) begin
        diff_p2 <= '0;
      end else if (cap_diff) begin
        diff_p2 <= AluResult;
      end
      // ---- accumulate ----
      if (clear) begin
        acc_p3 <= '0;
      end else if (cap_acc) begin
        acc_p3 <= AluResult;
      end
      // ---- result ----
      if (state == DONE) begin
        sad_q <= acc_p3;
      end
    end
  end

  // Next-state and ALU/memory drive; the ALU is driven only while it is granted.
  always_comb begin
    nstate   = state;
    clear    = 1'b0;
    step     = 1'b0;
    cap_diff = 1'b0;
    cap_acc  = 1'b0;
    AluReq   = 1'b0;
    MemRdEn  = 1'b0;
    AluA     = '0;
    AluB     = '0;
    AluCtl   = ALU_ADD;
    case (state)
      IDLE: begin
        if (Start) begin
          clear  = 1'b1;
          nstate = REQ;
        end
      end
      REQ: begin
        AluReq = 1'b1;
        if (AluGnt) nstate = RD;
      end
      RD: begin
        AluReq  = 1'b1;
        MemRdEn = 1'b1;
        nstate  = SUB;
      end
      SUB: begin
        AluReq = 1'b1;
        if (AluGnt) begin
          AluA     = opa_p1;
          AluB     = opb_p1;
          AluCtl   = ALU_SUB;
          cap_diff = 1'b1;
          nstate   = is_neg(AluResult) ? ABS : ACC;
        end
      end
      ABS: begin
        AluReq = 1'b1;
        if (AluGnt) begin
          AluA     = '0;
          AluB     = diff_p2;
          AluCtl   = ALU_SUB;
          cap_diff = 1'b1;
          nstate   = ACC;
        end
      end
      ACC: begin
        AluReq = 1'b1;
        if (AluGnt) begin
          AluA    = acc_p3;
          AluB    = diff_p2;
          AluCtl  = ALU_ADD;
          cap_acc = 1'b1;
          step    = 1'b1;
          nstate  = last ? DONE : RD;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);
  assign SadOut = Done ? acc_p3 : sad_q;

endmodule

// File: tb/tb_sad_alu_sequencer.sv
// Self-checking bench for sad_alu_sequencer: memory and ALU models, an
// element-by-element monitor, and a window-level SAD/latency reference.
module tb_sad_alu_sequencer;

  localparam int WIN_W   = 4;
  localparam int WIN_H   = 4;
  localparam int FRAME_W = 16;
  localparam int NEL     = WIN_W * WIN_H;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] BaseA = '0;
  logic [31:0] BaseB = '0;
  logic        MemRdEn;
  logic [31:0] MemAddrA, MemAddrB;
  logic [31:0] MemDataA = '0;
  logic [31:0] MemDataB = '0;
  logic        AluReq;
  logic        AluGnt = 1'b1;
  logic [31:0] AluA, AluB;
  logic [3:0]  AluCtl;
  logic [31:0] AluResult;
  logic        Busy, Done;
  logic [31:0] SadOut;

  sad_alu_sequencer #(
    .WIN_W  (WIN_W),
    .WIN_H  (WIN_H),
    .FRAME_W(FRAME_W)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .BaseA    (BaseA),
    .BaseB    (BaseB),
    .MemRdEn  (MemRdEn),
    .MemAddrA (MemAddrA),
    .MemAddrB (MemAddrB),
    .MemDataA (MemDataA),
    .MemDataB (MemDataB),
    .AluReq   (AluReq),
    .AluGnt   (AluGnt),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluCtl   (AluCtl),
    .AluResult(AluResult),
    .Busy     (Busy),
    .Done     (Done),
    .SadOut   (SadOut)
  );

  always #5 Clk = ~Clk;

  // Shared EX-stage ALU: combinational add/subtract.
  assign AluResult = (AluCtl == 4'b0001) ? (AluA - AluB) : (AluA + AluB);

  // Data memory: synchronous read; garbage on the ports whenever no read was issued.
  logic [31:0] mem [0:1023];
  always @(posedge Clk) begin
    if (MemRdEn) begin
      MemDataA <= mem[MemAddrA[11:2]];
      MemDataB <= mem[MemAddrB[11:2]];
    end else begin
      MemDataA <= $urandom;
      MemDataB <= $urandom;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Monitor state
  logic [31:0] cap_a = '0, cap_b = '0, va = '0, vb = '0, dv = '0;
  logic [31:0] rd_log_a [NEL];
  logic [31:0] rd_log_b [NEL];
  int rd_idx = 0, phase = 0, gnt_cnt = 0, gnt_mode = 0, stall_elem = 2, done_cnt = 0;
  logic next_gnt;

  task automatic monitor();
    int r, c;
    logic [31:0] ea, eb;
    forever begin
      @(negedge Clk);
      next_gnt = 1'b1;
      if (!Rst) begin
        rd_idx = 0; phase = 0; gnt_cnt = 0;
      end else begin
        if (Start && !Busy) begin
          cap_a = BaseA; cap_b = BaseB; rd_idx = 0; phase = 0; gnt_cnt = 0;
        end
        if (Done) done_cnt++;
        if (Busy) chk("alu_req", 32'(AluReq), 32'(!Done));
        else begin
          chk("idle_ctl", 32'({AluReq, MemRdEn, AluCtl}), 32'd0);
          chk("idle_ops", AluA | AluB, 32'd0);
        end
        if (Busy && !AluGnt) begin
          chk("gnt_low_ctl", 32'(AluCtl), 32'd0);
          chk("gnt_low_ops", AluA | AluB, 32'd0);
        end
        // grant pattern for the next cycle
        if (gnt_mode == 2) next_gnt = ($urandom_range(0, 3) != 0);
        else if (gnt_mode == 1 && gnt_cnt > 0) begin
          gnt_cnt--;
          next_gnt = (gnt_cnt == 0);
        end
        if (MemRdEn && rd_idx < NEL) begin
          r  = rd_idx / WIN_W;
          c  = rd_idx % WIN_W;
          ea = cap_a + 32'(4 * (r * FRAME_W + c));
          eb = cap_b + 32'(4 * (r * FRAME_W + c));
          chk("rd_addr_a", MemAddrA, ea);
          chk("rd_addr_b", MemAddrB, eb);
          rd_log_a[rd_idx] = MemAddrA;
          rd_log_b[rd_idx] = MemAddrB;
          va = mem[ea[11:2]];
          vb = mem[eb[11:2]];
          if (gnt_mode == 1 && rd_idx == stall_elem) begin
            gnt_cnt  = 5;
            next_gnt = 1'b0;
          end
          phase = 1;
          rd_idx++;
        end
        if (Busy && AluGnt && AluCtl == 4'b0001) begin
          chk("sub_expected", 32'(phase != 0), 32'd1);
          if (phase == 1) begin
            chk("sub_a", AluA, va);
            chk("sub_b", AluB, vb);
            dv    = va - vb;
            phase = dv[31] ? 2 : 0;
          end else if (phase == 2) begin
            chk("abs_a", AluA, 32'd0);
            chk("abs_b", AluB, dv);
            phase = 0;
          end
        end
      end
      @(posedge Clk);
      #1;
      AluGnt = next_gnt;
    end
  endtask

  // Fill memory with noise, then place the two windows.
  task automatic load(input logic [31:0] ba, input logic [31:0] bb, input int kind);
    int ia, ib;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        ia = int'(ba[11:2]) + r * FRAME_W + c;
        ib = int'(bb[11:2]) + r * FRAME_W + c;
        case (kind)
          0: begin mem[ia] = 32'd5; mem[ib] = 32'd3; end
          1: begin mem[ia] = 32'd3; mem[ib] = 32'd5; end
          2: begin mem[ia] = 32'h7FFF_FFFF; mem[ib] = 32'h8000_0000; end
          default: begin
            if ($urandom_range(0, 1) == 1) begin
              mem[ia] = $urandom_range(0, 1000);
              mem[ib] = $urandom_range(0, 1000);
            end else begin
              mem[ia] = $urandom;
              mem[ib] = $urandom;
            end
          end
        endcase
      end
    end
  endtask

  // Reference: SAD over the window and the Done cycle with the ALU always granted.
  task automatic model(input logic [31:0] ba, input logic [31:0] bb,
                       output logic [31:0] sad, output int cyc);
    logic [31:0] a, b, d;
    sad = 32'd0;
    cyc = 2;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        a = mem[int'(ba[11:2]) + r * FRAME_W + c];
        b = mem[int'(bb[11:2]) + r * FRAME_W + c];
        d = a - b;
        if (d[31]) begin
          d   = 32'd0 - d;
          cyc = cyc + 4;
        end else begin
          cyc = cyc + 3;
        end
        sad = sad + d;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ba, input logic [31:0] bb,
                     input int mode, input bit cyc_chk, input int extra,
                     input int poke, input bit start_in_done);
    logic [31:0] esad;
    int ecyc, c, d0;
    model(ba, bb, esad, ecyc);
    ecyc     = ecyc + extra;
    gnt_mode = mode;
    d0       = done_cnt;
    @(posedge Clk); #2;
    BaseA = ba; BaseB = bb; Start = 1'b1;
    @(posedge Clk); #2;
    Start = 1'b0; BaseA = 32'hDEAD_0000; BaseB = 32'hBEEF_0000;
    @(negedge Clk);
    c = 1;
    while (!Done && c < 400) begin
      if (c == poke) begin
        Start = 1'b1; BaseA = 32'h800; BaseB = 32'hC00;
        @(posedge Clk); #2;
        Start = 1'b0;
      end
      @(negedge Clk);
      c++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    if (cyc_chk) chk({tag, "_cycle"}, c, ecyc);
    chk({tag, "_sad"}, SadOut, esad);
    chk({tag, "_reads"}, rd_idx, NEL);
    if (start_in_done) Start = 1'b1;
    @(posedge Clk); #2;
    Start = 1'b0;
    @(negedge Clk);
    chk({tag, "_idle_after"}, 32'({Busy, Done}), 32'd0);
    chk({tag, "_pulses"}, done_cnt - d0, 32'd1);
    chk({tag, "_sad_hold"}, SadOut, esad);
    gnt_mode = 0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({MemRdEn, AluReq, AluCtl, Busy, Done}), 32'd0);
    chk({tag, "_addr"}, MemAddrA | MemAddrB, 32'd0);
    chk({tag, "_ops"}, AluA | AluB, 32'd0);
    chk({tag, "_sad"}, SadOut, 32'd0);
  endtask

  task automatic abort_at(input int when);
    int c, d0;
    gnt_mode = 0;
    d0 = done_cnt;
    @(posedge Clk); #2;
    BaseA = 32'h100; BaseB = 32'h400; Start = 1'b1;
    @(posedge Clk); #2;
    Start = 1'b0;
    @(negedge Clk);
    c = 1;
    while (c < when) begin
      @(negedge Clk);
      c++;
    end
    Rst = 1'b0;
    #1;
    reset_outputs("abort_rst");
    repeat (2) @(negedge Clk);
    @(posedge Clk); #2;
    Rst = 1'b1;
    repeat (60) @(negedge Clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_idle", 32'(Busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ba, bb;
    int mode;
    fork
      monitor();
    join_none

    load(32'h100, 32'h400, 0);
    repeat (3) @(negedge Clk);
    reset_outputs("reset");
    @(posedge Clk); #2;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // 1: A>B everywhere, ALU always granted
    run("c1", 32'h100, 32'h400, 0, 1'b1, 0, 0, 1'b0);
    // 2: A<B everywhere, every element takes the ABS pass
    load(32'h100, 32'h400, 1);
    run("c2", 32'h100, 32'h400, 0, 1'b1, 0, 0, 1'b0);
    // 3: grant withdrawn for 5 cycles during the third SUB
    load(32'h100, 32'h400, 0);
    run("c3", 32'h100, 32'h400, 1, 1'b1, 5, 0, 1'b0);
    // 4: address walk with random data
    load(32'h100, 32'h400, 3);
    run("c4", 32'h100, 32'h400, 0, 1'b1, 0, 0, 1'b0);
    chk("c4_e10_a", rd_log_a[4], 32'h140);
    chk("c4_e10_b", rd_log_b[4], 32'h440);
    chk("c4_e33_a", rd_log_a[15], 32'h1CC);
    chk("c4_e33_b", rd_log_b[15], 32'h4CC);
    // 5: overflowing difference
    load(32'h100, 32'h400, 2);
    run("c5", 32'h100, 32'h400, 0, 1'b1, 0, 0, 1'b0);
    // 6: Start while busy / in DONE ignored, reset abort, then a clean rerun
    load(32'h100, 32'h400, 0);
    run("c6", 32'h100, 32'h400, 0, 1'b1, 0, 10, 1'b1);
    abort_at(20);
    run("c6_rerun", 32'h100, 32'h400, 0, 1'b1, 0, 0, 1'b0);

    // random windows, bases and grant patterns
    for (int i = 0; i < 6; i++) begin
      ba   = 32'($urandom_range(0, 127) * 4);
      bb   = 32'h400 + 32'($urandom_range(0, 127) * 4);
      mode = (i % 2 == 0) ? 0 : 2;
      load(ba, bb, 3);
      run("rnd", ba, bb, mode, (mode == 0), 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
